// File: rtl/hello_scroll_display.sv
// Scrolls HELLO letter codes right-to-left across NUM_DIGITS seven-segment digits.
// A prescaler paces the scroll and emits a one-cycle step pulse to the upstream sequencer.
module hello_scroll_display #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 25_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [2:0]              char_in_i,
  input  logic                    char_valid_i,
  input  logic                    hold_i,
  output logic                    step_o,
  output logic [3*NUM_DIGITS-1:0] digits_o,
  output logic [7*NUM_DIGITS-1:0] segments_o
);

  localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic            SEG_INV = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3*NUM_DIGITS-1:0]   digits_q, digits_d;
  logic [7*NUM_DIGITS-1:0]   seg_q, seg_d;
  logic                      tick_s;

  // Codes above O are not letters and display as Blank.
  function automatic logic [2:0] sanitise(input logic [2:0] code);
    logic [2:0] res;
    if (code > 3'd4) begin
      res = 3'b000;
    end else begin
      res = code;
    end
    return res;
  endfunction

  function automatic logic [6:0] decode(input logic [2:0] code);
    logic [6:0] pat;
    case (code)
      3'd1:    pat = 7'b1110110;
      3'd2:    pat = 7'b1111001;
      3'd3:    pat = 7'b0111000;
      3'd4:    pat = 7'b0111111;
      default: pat = 7'b0000000;
    endcase
    if (SEG_INV) begin
      pat = ~pat;
    end else begin
      pat = pat;
    end
    return pat;
  endfunction

  // Reset wins over a terminal count so no step escapes during reset.
  assign tick_s = (cnt_q == CNT_LAST) && !hold_i && !reset_i;

  // Next-state for prescaler, digit shift register and segment pipeline.
  always_comb begin
    cnt_d    = cnt_q;
    digits_d = digits_q;
    seg_d    = seg_q;
    if (!hold_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (tick_s) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        digits_d[3*k +: 3] = digits_q[3*(k-1) +: 3];
      end
      if (char_valid_i) begin
        digits_d[2:0] = sanitise(char_in_i);
      end else begin
        digits_d[2:0] = 3'b000;
      end
    end else begin
      digits_d = digits_q;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_d[7*k +: 7] = decode(digits_q[3*k +: 3]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      digits_q <= '0;
      seg_q    <= SEG_INV ? {(7*NUM_DIGITS){1'b1}} : {(7*NUM_DIGITS){1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      seg_q    <= seg_d;
    end
  end

  assign step_o     = tick_s;
  assign digits_o   = digits_q;
  assign segments_o = seg_q;

endmodule
